spi_reg_bank: RTL and testbench

- Register-bank stage directly downstream of the SPI slave shifter: consumes the received byte (data_out) on each done, and feeds the slave's parallel transmit byte (data_in).
- Decodes a command byte followed by data bytes, and implements a small register file with auto-increment bursts.
- Read data is returned in the following frame, because the slave loads data_in only while cs is high.
- Clocked on sclk, like the slave.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_cmd_fsm.sv | 81 ++++++++
 rtl/spi_reg_bank.sv | 102 ++++++++++
 tb/tb_spi_reg_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI register bank slice.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        CMD = 2'd0,
        WR  = 2'd1,
        RD  = 2'd2
    } state_t;

    localparam int         c_rw_bit         = 7;
    localparam logic [7:0] c_id_val_default = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/spi_cmd_fsm.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_fsm
// Description : Command/data byte decoder with auto-increment write bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_fsm
    import spi_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic [7:0]        rx_byte,
    input  logic              rx_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              re,
    output logic [ADDR_W-1:0] raddr
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_rw;
    logic              w_rw_nxt;

    // Decode is independent of cs so the cs-edge update sees settled values.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_cur_addr;
        w_rw_nxt    = r_rw;
        we          = 1'b0;
        waddr       = r_cur_addr;
        wdata       = rx_byte;
        re          = 1'b0;
        raddr       = rx_byte[ADDR_W-1:0];
        if (rx_done) begin
            case (r_state)
                CMD: begin
                    w_rw_nxt   = rx_byte[c_rw_bit];
                    w_addr_nxt = rx_byte[ADDR_W-1:0];
                    if (rx_byte[c_rw_bit]) begin
                        re          = 1'b1;
                        w_state_nxt = RD;
                    end else begin
                        w_state_nxt = WR;
                    end
                end
                WR: begin
                    we         = !r_rw && (r_cur_addr != '0);
                    w_addr_nxt = r_cur_addr + ADDR_W'(1);
                end
                RD: begin
                    w_state_nxt = RD;
                end
                default: begin
                    w_state_nxt = CMD;
                end
            endcase
        end
    end

    // A cs rising edge commits any pending byte, then closes the frame.
    always_ff @(posedge sclk or posedge cs or posedge rst) begin
        if (rst) begin
            r_state    <= CMD;
            r_cur_addr <= '0;
            r_rw       <= 1'b0;
        end else begin
            r_cur_addr <= w_addr_nxt;
            r_rw       <= w_rw_nxt;
            r_state    <= cs ? CMD : w_state_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bank
// Description : SPI-slave register file; address 0 is a read-only ID byte.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int         ADDR_W  = 4,
    parameter logic [7:0] ID_VAL  = c_id_val_default,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic                     rst,
    input  logic                     sclk,
    input  logic                     cs,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_done,
    output logic [7:0]               tx_byte,
    output logic [8*(2**ADDR_W)-1:0] regs_flat,
    output logic                     wr_pulse,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [7:0]               frame_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [7:0]        w_wdata;
    logic              w_re;
    logic [ADDR_W-1:0] w_raddr;
    logic [7:0]        w_rd_data;

    logic [7:0]        r_tx_byte;
    logic              r_wr_pulse;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_frame_cnt;

    spi_cmd_fsm #(
        .ADDR_W (ADDR_W)
    ) u_fsm (
        .rst     (rst),
        .sclk    (sclk),
        .cs      (cs),
        .rx_byte (rx_byte),
        .rx_done (rx_done),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .re      (w_re),
        .raddr   (w_raddr)
    );

    assign regs_flat[7:0] = ID_VAL;

    generate
        for (genvar k = 1; k < NREG; k++) begin : g_reg
            logic [7:0] r_val;

            always_ff @(posedge sclk or posedge cs or posedge rst) begin
                if (rst) begin
                    r_val <= RST_VAL;
                end else if (w_we && (w_waddr == ADDR_W'(k))) begin
                    r_val <= w_wdata;
                end
            end

            assign regs_flat[8*k +: 8] = r_val;
        end
    endgenerate

    // Slot 0 of regs_flat already carries ID_VAL, so one mux covers reads.
    assign w_rd_data = regs_flat[{w_raddr, 3'b000} +: 8];

    always_ff @(posedge sclk or posedge cs or posedge rst) begin
        if (rst) begin
            r_tx_byte   <= 8'h00;
            r_wr_pulse  <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_cnt <= 8'h00;
        end else begin
            r_wr_pulse <= w_we;
            if (w_we) begin
                r_wr_addr <= w_waddr;
            end
            if (w_re) begin
                r_tx_byte <= w_rd_data;
            end
            if (cs) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign tx_byte   = r_tx_byte;
    assign wr_pulse  = r_wr_pulse;
    assign wr_addr   = r_wr_addr;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_bank
// Description : Directed self-checking bench for spi_reg_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bank;

    logic         rst;
    logic         sclk;
    logic         cs;
    logic [7:0]   rx_byte;
    logic         rx_done;
    logic [7:0]   tx_byte;
    logic [127:0] regs_flat;
    logic         wr_pulse;
    logic [3:0]   wr_addr;
    logic [7:0]   frame_cnt;

    int           n_cmp;
    int           n_err;
    int           pulse_cnt;
    logic [127:0] exp_flat;

    spi_reg_bank #(
        .ADDR_W  (4),
        .ID_VAL  (8'hA5),
        .RST_VAL (8'h00)
    ) dut (
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .rx_byte   (rx_byte),
        .rx_done   (rx_done),
        .tx_byte   (tx_byte),
        .regs_flat (regs_flat),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .frame_cnt (frame_cnt)
    );

    always @(posedge wr_pulse) pulse_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sclk_pulse();
        #5 sclk = 1'b1;
        #5 sclk = 1'b0;
    endtask

    // Eight shift edges, then the byte is presented; the last byte of a frame
    // is taken by the cs rising edge instead of a ninth sclk edge.
    task automatic send_byte(input logic [7:0] v, input bit last);
        rx_done = 1'b0;
        repeat (8) sclk_pulse();
        rx_byte = v;
        rx_done = 1'b1;
        if (!last) begin
            sclk_pulse();
            rx_done = 1'b0;
        end else begin
            #5 cs = 1'b1;
            #5 rx_done = 1'b0;
        end
    endtask

    task automatic frame_start();
        #5 cs = 1'b0;
        #5;
    endtask

    function automatic logic [7:0] reg_of(input int k);
        return regs_flat[8*k +: 8];
    endfunction

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        pulse_cnt = 0;
        sclk      = 1'b0;
        cs        = 1'b1;
        rx_byte   = 8'h00;
        rx_done   = 1'b0;
        rst       = 1'b1;
        #12 rst   = 1'b0;
        #5;

        exp_flat        = '0;
        exp_flat[7:0]   = 8'hA5;
        check("rst_tx", tx_byte, 8'h00);
        check("rst_wr_pulse", wr_pulse, 1'b0);
        check("rst_wr_addr", wr_addr, 4'h0);
        check("rst_frame_cnt", frame_cnt, 8'h00);
        check("rst_regs", regs_flat, exp_flat);

        // Read of address 0 returns the ID byte.
        frame_start();
        send_byte(8'h80, 1);
        check("rd0_tx", tx_byte, 8'hA5);
        check("rd0_frame_cnt", frame_cnt, 8'd1);

        // Single write, data byte taken on the cs edge.
        frame_start();
        send_byte(8'h03, 0);
        send_byte(8'h5C, 1);
        exp_flat[8*3 +: 8] = 8'h5C;
        check("wr3_regs", regs_flat, exp_flat);
        check("wr3_pulse", wr_pulse, 1'b1);
        check("wr3_addr", wr_addr, 4'h3);
        check("wr3_frame_cnt", frame_cnt, 8'd2);

        // Empty frame: cs toggles with no clocks; pulse cleared on cs edge.
        #5 cs = 1'b0;
        #5 cs = 1'b1;
        #5;
        check("empty_pulse", wr_pulse, 1'b0);
        check("empty_frame_cnt", frame_cnt, 8'd3);
        check("empty_regs", regs_flat, exp_flat);

        // Partial frame: five bits then deselect.
        frame_start();
        repeat (5) sclk_pulse();
        #5 cs = 1'b1;
        #5;
        check("partial_frame_cnt", frame_cnt, 8'd4);
        check("partial_regs", regs_flat, exp_flat);

        // Burst from 14 wraps through read-only address 0 to address 1.
        pulse_cnt = 0;
        frame_start();
        send_byte(8'h0E, 0);
        send_byte(8'h11, 0);
        check("burst_pulse_hi", wr_pulse, 1'b1);
        check("burst_addr14", wr_addr, 4'hE);
        check("burst_reg14", reg_of(14), 8'h11);
        sclk_pulse();
        check("burst_pulse_lo", wr_pulse, 1'b0);
        rx_done = 1'b0;
        repeat (7) sclk_pulse();
        rx_byte = 8'h22;
        rx_done = 1'b1;
        sclk_pulse();
        rx_done = 1'b0;
        send_byte(8'h33, 0);
        check("burst_drop0_pulse", wr_pulse, 1'b0);
        send_byte(8'h44, 1);
        exp_flat[8*14 +: 8] = 8'h11;
        exp_flat[8*15 +: 8] = 8'h22;
        exp_flat[8*1  +: 8] = 8'h44;
        check("burst_regs", regs_flat, exp_flat);
        check("burst_pulse_cnt", pulse_cnt, 3);
        check("burst_last_addr", wr_addr, 4'h1);
        check("burst_frame_cnt", frame_cnt, 8'd5);

        // Read-back: data appears in tx_byte for the following frame.
        frame_start();
        send_byte(8'h8E, 1);
        check("rd14_tx", tx_byte, 8'h11);
        check("rd14_frame_cnt", frame_cnt, 8'd6);
        frame_start();
        check("rd14_tx_held", tx_byte, 8'h11);
        send_byte(8'h00, 1);
        check("cmd_only_regs", regs_flat, exp_flat);
        check("cmd_only_tx", tx_byte, 8'h11);
        check("cmd_only_frame_cnt", frame_cnt, 8'd7);

        // Bytes after a read command are ignored.
        frame_start();
        send_byte(8'h8F, 0);
        check("rd15_tx", tx_byte, 8'h22);
        send_byte(8'h55, 1);
        check("rd_ignore_tx", tx_byte, 8'h22);
        check("rd_ignore_regs", regs_flat, exp_flat);
        check("rd_ignore_pulse", pulse_cnt, 3);

        // Reset mid-burst.
        frame_start();
        send_byte(8'h05, 0);
        send_byte(8'hAA, 0);
        check("mid_reg5", reg_of(5), 8'hAA);
        #3 rst = 1'b1;
        #3 rst = 1'b0;
        #2;
        exp_flat      = '0;
        exp_flat[7:0] = 8'hA5;
        check("mid_rst_regs", regs_flat, exp_flat);
        check("mid_rst_tx", tx_byte, 8'h00);
        check("mid_rst_frame_cnt", frame_cnt, 8'h00);
        check("mid_rst_wr_addr", wr_addr, 4'h0);
        check("mid_rst_pulse", wr_pulse, 1'b0);
        #5 cs = 1'b1;
        #5;
        check("post_rst_frame_cnt", frame_cnt, 8'd1);
        frame_start();
        send_byte(8'h06, 0);
        send_byte(8'h77, 1);
        exp_flat[8*6 +: 8] = 8'h77;
        check("post_rst_regs", regs_flat, exp_flat);
        check("post_rst_wr_addr", wr_addr, 4'h6);
        check("post_rst_frame_cnt2", frame_cnt, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
